// File: rtl/frac_n_pkg.sv
// -----------------------------------------------------------------------------
// frac_n_pkg
// Shared definitions for the fractional-N divider controller:
//   - controller state encoding (IDLE / ARM / RUN, 2 bits)
//   - default smallest legal modulus
//   - legal output range of the MASH 1-1-1 modulator feeding y_i
// -----------------------------------------------------------------------------
package frac_n_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_RUN  = 2'd2
  } div_state_e;

  localparam int N_MIN_DEF = 4;

  // A third-order MASH 1-1-1 produces samples in -3..+4.
  localparam int Y_MIN = -3;
  localparam int Y_MAX = 4;

endpackage : frac_n_pkg

// File: rtl/frac_n_mod_calc.sv
// -----------------------------------------------------------------------------
// frac_n_mod_calc
// Combinational modulus for one divider period: N = n_int + sign-extended y,
// evaluated in N_WIDTH+2 signed bits so neither the maximum (n_int all ones
// plus +4) nor a negative sum can wrap. Sums below N_MIN are clamped to N_MIN.
//
// Ports:
//   n_int_i    [N_WIDTH-1:0]  unsigned integer divide ratio
//   y_i        [Y_WIDTH-1:0]  two's-complement MASH sample
//   n_o        [N_WIDTH:0]    resulting modulus (always >= N_MIN)
//   clamped_o                 1 when the raw sum was below N_MIN
// -----------------------------------------------------------------------------
module frac_n_mod_calc
  import frac_n_pkg::*;
#(
  parameter int N_WIDTH = 8,
  parameter int Y_WIDTH = 4,
  parameter int N_MIN   = N_MIN_DEF
) (
  input  logic [N_WIDTH-1:0] n_int_i,
  input  logic [Y_WIDTH-1:0] y_i,
  output logic [N_WIDTH:0]   n_o,
  output logic               clamped_o
);

  localparam int SW = N_WIDTH + 2;

  localparam logic signed [SW-1:0] N_MIN_S = SW'(N_MIN);
  localparam logic [N_WIDTH:0]     N_MIN_U = (N_WIDTH + 1)'(N_MIN);

  logic signed [SW-1:0] n_ext;
  logic signed [SW-1:0] y_ext;
  logic signed [SW-1:0] sum;

  assign n_ext = signed'({2'b00, n_int_i});
  assign y_ext = signed'({{(SW - Y_WIDTH){y_i[Y_WIDTH-1]}}, y_i});
  assign sum   = n_ext + y_ext;

  assign clamped_o = (sum < N_MIN_S);
  // Once clamping has been ruled out, the sum is positive and at most
  // 2^N_WIDTH + 3, so its low N_WIDTH+1 bits hold it exactly.
  assign n_o       = clamped_o ? N_MIN_U : sum[N_WIDTH:0];

endmodule : frac_n_mod_calc

// File: rtl/frac_n_div_ctrl.sv
// -----------------------------------------------------------------------------
// frac_n_div_ctrl
// Fractional-N divider controller. Each period lasts n_cur_o cycles; the
// period length is resampled from n_int_i + y_i in the last cycle of every
// period (tick_o), so consecutive periods follow with no gap. div_o is high
// for ceil(N/2) cycles and then low for floor(N/2) cycles.
//
// Ports:
//   clk, rst_n                  clock (rising edge), async active-low reset
//   en_i                        run enable, acted on only in IDLE or at a tick
//   n_int_i  [N_WIDTH-1:0]      integer divide ratio
//   y_i      [Y_WIDTH-1:0]      MASH sample, -3..+4
//   div_o                       divided clock, registered
//   tick_o                      strobe in the last cycle of each period
//   n_cur_o  [N_WIDTH:0]        modulus of the period in progress
//   busy_o                      high in ARM and RUN
//   err_o                       sticky: a modulus was clamped since last ARM
// -----------------------------------------------------------------------------
module frac_n_div_ctrl
  import frac_n_pkg::*;
#(
  parameter int N_WIDTH = 8,
  parameter int Y_WIDTH = 4,
  parameter int N_MIN   = N_MIN_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en_i,
  input  logic [N_WIDTH-1:0] n_int_i,
  input  logic [Y_WIDTH-1:0] y_i,
  output logic               div_o,
  output logic               tick_o,
  output logic [N_WIDTH:0]   n_cur_o,
  output logic               busy_o,
  output logic               err_o
);

  localparam logic [N_WIDTH:0] CNT_ONE = (N_WIDTH + 1)'(1);

  logic [N_WIDTH:0] n_calc;
  logic             n_clamped;

  frac_n_mod_calc #(
    .N_WIDTH (N_WIDTH),
    .Y_WIDTH (Y_WIDTH),
    .N_MIN   (N_MIN)
  ) u_mod_calc (
    .n_int_i   (n_int_i),
    .y_i       (y_i),
    .n_o       (n_calc),
    .clamped_o (n_clamped)
  );

  div_state_e       state_q, state_d;
  logic [N_WIDTH:0] cnt_q,   cnt_d;
  logic [N_WIDTH:0] n_cur_q, n_cur_d;
  logic             err_q,   err_d;
  logic             div_q,   div_d;
  logic             tick_q,  tick_d;
  logic             busy_q,  busy_d;

  // cnt counts down from N-1 to 0 over one period.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned; an unassigned path would infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    n_cur_d = n_cur_q;
    err_d   = err_q;

    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (en_i) state_d = ST_ARM;
      end
      ST_ARM: begin
        state_d = ST_RUN;
        n_cur_d = n_calc;
        cnt_d   = n_calc - CNT_ONE;
        err_d   = n_clamped;          // a fresh start clears the sticky flag
      end
      ST_RUN: begin
        if (cnt_q == '0) begin
          if (en_i) begin
            n_cur_d = n_calc;
            cnt_d   = n_calc - CNT_ONE;
            err_d   = err_q | n_clamped;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Outputs are derived from next-state values so the registered copies
    // line up with the cycle they describe.
    div_d  = (state_d == ST_RUN) && (cnt_d >= (n_cur_d >> 1));
    tick_d = (state_d == ST_RUN) && (cnt_d == '0);
    busy_d = (state_d != ST_IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of the others, independent of statement order.
  // NOTE: all of this state is a handful of flops, so every one is reset
  // asynchronously; a reset mid-period aborts it on the spot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      n_cur_q <= '0;
      err_q   <= 1'b0;
      div_q   <= 1'b0;
      tick_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      n_cur_q <= n_cur_d;
      err_q   <= err_d;
      div_q   <= div_d;
      tick_q  <= tick_d;
      busy_q  <= busy_d;
    end
  end

  assign div_o   = div_q;
  assign tick_o  = tick_q;
  assign n_cur_o = n_cur_q;
  assign busy_o  = busy_q;
  assign err_o   = err_q;

endmodule : frac_n_div_ctrl

// File: doc/frac_n_div_ctrl.md
FRAC_N_DIV_CTRL -- requirements
Module: frac_n_div_ctrl

Interface
REQ-001 SHALL have parameter N_WIDTH, default 8, width of integer divide ratio n_int_i.
REQ-002 SHALL have parameter Y_WIDTH, default 4, width of signed MASH sample y_i.
REQ-003 SHALL have parameter N_MIN, default 4, smallest legal modulus.
REQ-004 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port en_i  input  1  run enable.
REQ-007 SHALL have port n_int_i  input  N_WIDTH  unsigned integer divide ratio.
REQ-008 SHALL have port y_i  input  Y_WIDTH  two's-complement MASH 1-1-1 output, legal range -3..+4.
REQ-009 SHALL have port div_o  output  1  divided clock, registered.
REQ-010 SHALL have port tick_o  output  1  one-cycle strobe in the last cycle of each period; requests the next MASH sample.
REQ-011 SHALL have port n_cur_o  output  N_WIDTH+1  modulus of the period in progress.
REQ-012 SHALL have port busy_o  output  1  high in ARM and RUN.
REQ-013 SHALL have port err_o  output  1  sticky flag: a modulus was clamped.

Function
REQ-014 SHALL compute the modulus as N = n_int_i + sign-extended y_i in N_WIDTH+2 signed bits; if N < N_MIN, SHALL use N_MIN and set err_o.
REQ-015 SHALL implement states IDLE, ARM, RUN, with 2-bit encoding from the shared package.
REQ-016 IDLE -> ARM SHALL occur when en_i=1; ARM SHALL last exactly one cycle, latch N into n_cur_o, load cnt=N-1, clear err_o (unless N is clamped in that cycle), then go to RUN.
REQ-017 RUN SHALL decrement cnt by 1 per cycle; at cnt==0, tick_o SHALL be 1 for that cycle.
REQ-018 At cnt==0 with en_i=1, N SHALL be resampled from n_int_i/y_i in that same cycle and SHALL take effect in the next cycle (cnt=N-1, n_cur_o=N).
REQ-019 Period length SHALL equal exactly n_cur_o cycles; consecutive periods SHALL have no gap.
REQ-020 div_o SHALL be 1 while cnt >= floor(n_cur_o/2), else 0: ceil(N/2) cycles high, floor(N/2) cycles low, registered from the next-state cnt.
REQ-021 en_i falling mid-period SHALL NOT truncate the period; at cnt==0, tick_o SHALL still pulse, then the FSM SHALL go to IDLE with div_o=0.
REQ-022 en_i toggled in a cycle other than cnt==0 SHALL have no effect until cnt==0.
REQ-023 Input changes between ticks SHALL be ignored; inputs are sampled only in ARM and at cnt==0.
REQ-024 In IDLE: div_o=0, tick_o=0, busy_o=0; n_cur_o and err_o SHALL hold their last values.
REQ-025 err_o SHALL remain set until reset or the next ARM.

Reset
REQ-026 rst_n low SHALL asynchronously force state=IDLE, cnt=0, div_o=0, tick_o=0, n_cur_o=0, busy_o=0, err_o=0.
REQ-027 Reset asserted mid-period SHALL abort the period immediately; after release, ARM SHALL be re-entered only on en_i=1.

Structure
REQ-028 A shared package frac_n_pkg SHALL hold the state encoding, N_MIN default and the MASH range constants Y_MIN=-3, Y_MAX=+4.
REQ-029 Modulus computation and clamp SHALL be one combinational sub-module frac_n_mod_calc (inputs n_int, y; outputs N, clamped).
REQ-030 All other state SHALL reside in frac_n_div_ctrl.

Verification
REQ-031 n_int_i=10, y_i=0, en_i=1: first tick_o 10 cycles after ARM, then every 10 cycles; div_o 5 high / 5 low; n_cur_o=10.
REQ-032 n_int_i=10, y_i alternating +4/-3 per tick: periods 14, 7, 14, 7; div_o 7/7 then 4/3.
REQ-033 n_int_i=2, y_i=-3: n_cur_o=4, err_o=1; next ARM with n_int_i=10 clears err_o.
REQ-034 en_i dropped 3 cycles into an N=12 period: tick_o after 12 cycles total, then IDLE with div_o=0 and busy_o=0.
REQ-035 rst_n pulsed low mid-period: all outputs 0 within the same cycle; no tick_o until en_i=1 and ARM completes.
REQ-036 n_int_i=255, y_i=+4: n_cur_o=259 with no wrap; period 259 cycles, div_o 130 high / 129 low.
